clock_divider_bank: RTL and testbench

CLOCK_DIVIDER_BANK -- requirements
Module: clock_divider_bank

---
 rtl/clk_div_pkg.sv | 14 +
 rtl/clk_div_channel.sv | 71 +++++++
 rtl/clock_divider_bank.sv | 47 ++++
 tb/tb_clock_divider_bank.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clk_div_pkg.sv
// clk_div_pkg: shared defaults and the channel-index width helper for the
// clock divider bank.
package clk_div_pkg;

   localparam int DEFAULT_DIV = 100;
   localparam int DEF_NUM_CH  = 4;
   localparam int DEF_CNT_W   = 7;

   // A single-channel bank still gets a 1-bit channel select.
   function automatic int ch_idx_w(input int num_ch);
      return (num_ch > 1) ? $clog2(num_ch) : 1;
   endfunction

endpackage

// File: rtl/clk_div_channel.sv
// clk_div_channel: one divider channel with shadow/active divisors and a
// glitch-free retarget. Optional CLKDIV_SYNC_RESTART_EN adds sync_restart.
module clk_div_channel
   import clk_div_pkg::*;
#(
   parameter int CNT_W       = DEF_CNT_W,
   parameter int DEFAULT_DIV = clk_div_pkg::DEFAULT_DIV
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             wr,
   input  logic [CNT_W-1:0] wr_div,
`ifdef CLKDIV_SYNC_RESTART_EN
   input  logic             sync_restart,
`endif
   output logic             scaled_clk,
   output logic             tick
);

   localparam logic [CNT_W-1:0] RST_DIV = CNT_W'(DEFAULT_DIV);

   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] shadow;
   logic [CNT_W-1:0] active;
   logic             term;
   logic             parked;

   // cnt never exceeds active, so equality is the terminal condition; a zero
   // divisor therefore terminates every cycle, which lets a parked channel
   // pick up a new shadow on the very next edge.
   assign term   = (cnt == active);
   assign parked = (active == '0);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt        <= '0;
         shadow     <= RST_DIV;
         active     <= RST_DIV;
         scaled_clk <= 1'b0;
         tick       <= 1'b0;
      end else begin
         if (wr)
            shadow <= wr_div;
`ifdef CLKDIV_SYNC_RESTART_EN
         if (sync_restart) begin
            cnt        <= '0;
            active     <= shadow;
            scaled_clk <= 1'b0;
            tick       <= 1'b0;
         end else
`endif
         if (!en) begin
            tick   <= 1'b0;
            active <= shadow;
            // Keep the frozen count within a smaller newly loaded divisor.
            if (cnt > shadow)
               cnt <= shadow;
         end else if (term) begin
            cnt        <= '0;
            active     <= shadow;
            scaled_clk <= parked ? 1'b0 : ~scaled_clk;
            tick       <= ~parked;
         end else begin
            cnt  <= cnt + CNT_W'(1);
            tick <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/clock_divider_bank.sv
// clock_divider_bank: NUM_CH independent clock dividers sharing one divisor
// write port. Define CLKDIV_SYNC_RESTART_EN to add the sync_restart input.
module clock_divider_bank
   import clk_div_pkg::*;
#(
   parameter int  NUM_CH      = DEF_NUM_CH,
   parameter int  CNT_W       = DEF_CNT_W,
   parameter int  DEFAULT_DIV = clk_div_pkg::DEFAULT_DIV,
   localparam int CH_W        = ch_idx_w(NUM_CH)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [NUM_CH-1:0] ch_en,
   input  logic              wr_en,
   input  logic [CH_W-1:0]   wr_ch,
   input  logic [CNT_W-1:0]  wr_div,
`ifdef CLKDIV_SYNC_RESTART_EN
   input  logic              sync_restart,
`endif
   output logic [NUM_CH-1:0] scaled_clk,
   output logic [NUM_CH-1:0] tick
);

   logic [NUM_CH-1:0] wr_sel;

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      // Channel indices at or above NUM_CH match no channel and are dropped.
      assign wr_sel[i] = wr_en && (wr_ch == CH_W'(i));

      clk_div_channel #(
         .CNT_W       (CNT_W),
         .DEFAULT_DIV (DEFAULT_DIV)
      ) u_ch (
         .clk          (clk),
         .reset        (reset),
         .en           (ch_en[i]),
         .wr           (wr_sel[i]),
         .wr_div       (wr_div),
`ifdef CLKDIV_SYNC_RESTART_EN
         .sync_restart (sync_restart),
`endif
         .scaled_clk   (scaled_clk[i]),
         .tick         (tick[i])
      );
   end

endmodule

// File: tb/tb_clock_divider_bank.sv
// tb_clock_divider_bank: directed and randomized checks of clock_divider_bank
// against closed-form expectations derived from enabled-cycle counts.
module tb_clock_divider_bank;

   localparam int NUM_CH = 4;
   localparam int CNT_W  = 7;
   localparam int DEF    = 100;

   logic              clk = 1'b0;
   logic              reset;
   logic [NUM_CH-1:0] ch_en;
   logic              wr_en;
   logic [1:0]        wr_ch;
   logic [CNT_W-1:0]  wr_div;
   logic [NUM_CH-1:0] scaled_clk;
   logic [NUM_CH-1:0] tick;
`ifdef CLKDIV_SYNC_RESTART_EN
   logic              sync_restart;
`endif

   int n_chk  = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   clock_divider_bank #(
      .NUM_CH      (NUM_CH),
      .CNT_W       (CNT_W),
      .DEFAULT_DIV (DEF)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .ch_en        (ch_en),
      .wr_en        (wr_en),
      .wr_ch        (wr_ch),
      .wr_div       (wr_div),
`ifdef CLKDIV_SYNC_RESTART_EN
      .sync_restart (sync_restart),
`endif
      .scaled_clk   (scaled_clk),
      .tick         (tick)
   );

   // Level after j enabled cycles of a segment with divisor d starting at level base.
   function automatic logic seg_lvl(input int j, input int d, input logic base);
      if (d == 0) return 1'b0;
      return base ^ (((j / (d + 1)) % 2) != 0);
   endfunction

   // A toggle (and tick) falls on every (d+1)-th enabled cycle of a segment.
   function automatic logic seg_tick(input int j, input int d);
      return (d > 0) && (j > 0) && ((j % (d + 1)) == 0);
   endfunction

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b0;
      ch_en = '0;
      wr_en = 1'b0;
      cyc();
      cyc();
      reset = 1'b1;
   endtask

   task automatic test_reset();
      reset  = 1'b0;
      ch_en  = '1;
      wr_en  = 1'b0;
      wr_ch  = '0;
      wr_div = '0;
      #2;
      n_chk++;
      if (scaled_clk !== 4'b0000) $display("FAIL reset_scaled got=%b want=0000", scaled_clk);
      else n_pass++;
      n_chk++;
      if (tick !== 4'b0000) $display("FAIL reset_tick got=%b want=0000", tick);
      else n_pass++;
      cyc();
      cyc();
      n_chk++;
      if ({scaled_clk, tick} !== 8'h00) $display("FAIL reset_held got=%b/%b want=0000/0000", scaled_clk, tick);
      else n_pass++;
   endtask

   task automatic test_default();
      logic [3:0] el, et;
      do_reset();
      ch_en = 4'b0001;
      for (int k = 1; k <= 404; k++) begin
         cyc();
         el = '0;
         et = '0;
         el[0] = seg_lvl(k, DEF, 1'b0);
         et[0] = seg_tick(k, DEF);
         n_chk++;
         if ({scaled_clk, tick} !== {el, et})
            $display("FAIL default k=%0d got=%b/%b want=%b/%b", k, scaled_clk, tick, el, et);
         else n_pass++;
      end
   endtask

   task automatic test_retarget();
      logic [3:0] el, et;
      do_reset();
      ch_en = 4'b0010;
      for (int k = 1; k <= 140; k++) begin
         cyc();
         el = '0;
         et = '0;
         if (k <= 101) begin
            el[1] = seg_lvl(k, DEF, 1'b0);
            et[1] = seg_tick(k, DEF);
         end else begin
            el[1] = seg_lvl(k - 101, 3, 1'b1);
            et[1] = seg_tick(k - 101, 3);
         end
         n_chk++;
         if ({scaled_clk, tick} !== {el, et})
            $display("FAIL retarget k=%0d got=%b/%b want=%b/%b", k, scaled_clk, tick, el, et);
         else n_pass++;
         wr_en  = (k == 49);
         wr_ch  = 2'd1;
         wr_div = 7'd3;
      end
      wr_en = 1'b0;
   endtask

   task automatic test_tc_write();
      logic [3:0] el, et;
      do_reset();
      ch_en = 4'b0100;
      for (int k = 1; k <= 250; k++) begin
         cyc();
         el = '0;
         et = '0;
         if (k <= 202) begin
            el[2] = seg_lvl(k, DEF, 1'b0);
            et[2] = seg_tick(k, DEF);
         end else begin
            el[2] = seg_lvl(k - 202, 5, 1'b0);
            et[2] = seg_tick(k - 202, 5);
         end
         n_chk++;
         if ({scaled_clk, tick} !== {el, et})
            $display("FAIL tc_write k=%0d got=%b/%b want=%b/%b", k, scaled_clk, tick, el, et);
         else n_pass++;
         // The write lands on edge 101, the first terminal count.
         wr_en  = (k == 100);
         wr_ch  = 2'd2;
         wr_div = 7'd5;
      end
      wr_en = 1'b0;
   endtask

   task automatic test_park();
      logic [3:0] el, et;
      do_reset();
      ch_en = 4'b1000;
      for (int k = 1; k <= 290; k++) begin
         cyc();
         el = '0;
         et = '0;
         if (k <= 202) begin
            el[3] = seg_lvl(k, DEF, 1'b0);
            et[3] = seg_tick(k, DEF);
         end else if (k > 262) begin
            el[3] = seg_lvl(k - 262, 1, 1'b0);
            et[3] = seg_tick(k - 262, 1);
         end
         n_chk++;
         if ({scaled_clk, tick} !== {el, et})
            $display("FAIL park k=%0d got=%b/%b want=%b/%b", k, scaled_clk, tick, el, et);
         else n_pass++;
         wr_en  = (k == 149) || (k == 260);
         wr_ch  = 2'd3;
         wr_div = (k == 149) ? 7'd0 : 7'd1;
      end
      wr_en = 1'b0;
   endtask

   task automatic test_freeze_and_reset();
      logic [3:0] el, et;
      int k;
      do_reset();
      ch_en = 4'b0001;
      k = 0;
      for (int t = 1; t <= 180; t++) begin
         cyc();
         if (ch_en[0]) k++;
         el = '0;
         et = '0;
         el[0] = seg_lvl(k, DEF, 1'b0);
         et[0] = ch_en[0] && seg_tick(k, DEF);
         n_chk++;
         if ({scaled_clk, tick} !== {el, et})
            $display("FAIL freeze t=%0d got=%b/%b want=%b/%b", t, scaled_clk, tick, el, et);
         else n_pass++;
         ch_en[0] = !((t >= 50) && (t < 70));
      end
      // Mid-period (high half) asynchronous reset, observed before the next edge.
      #3;
      reset = 1'b0;
      #1;
      n_chk++;
      if ({scaled_clk, tick} !== 8'h00)
         $display("FAIL async_reset got=%b/%b want=0000/0000", scaled_clk, tick);
      else n_pass++;
      cyc();
      reset = 1'b1;
      for (int j = 1; j <= 110; j++) begin
         cyc();
         el = '0;
         et = '0;
         el[0] = seg_lvl(j, DEF, 1'b0);
         et[0] = seg_tick(j, DEF);
         n_chk++;
         if ({scaled_clk, tick} !== {el, et})
            $display("FAIL post_reset j=%0d got=%b/%b want=%b/%b", j, scaled_clk, tick, el, et);
         else n_pass++;
      end
   endtask

   task automatic test_random();
      int dv [4];
      int k [4];
      logic [3:0] el, et;
      for (int r = 0; r < 6; r++) begin
         do_reset();
         for (int i = 0; i < 4; i++) dv[i] = $urandom_range(0, 12);
         if (r == 0) dv = '{127, 0, 1, 12};
         for (int i = 0; i < 4; i++) begin
            wr_en  = 1'b1;
            wr_ch  = 2'(i);
            wr_div = 7'(dv[i]);
            cyc();
         end
         wr_en = 1'b0;
         cyc();
         k = '{0, 0, 0, 0};
         for (int t = 0; t < 300; t++) begin
            for (int i = 0; i < 4; i++) ch_en[i] = ($urandom_range(0, 3) != 0);
            cyc();
            for (int i = 0; i < 4; i++) begin
               if (ch_en[i]) k[i]++;
               el[i] = seg_lvl(k[i], dv[i], 1'b0);
               et[i] = ch_en[i] && seg_tick(k[i], dv[i]);
            end
            n_chk++;
            if ({scaled_clk, tick} !== {el, et})
               $display("FAIL random r=%0d t=%0d got=%b/%b want=%b/%b", r, t, scaled_clk, tick, el, et);
            else n_pass++;
         end
      end
   endtask

`ifdef CLKDIV_SYNC_RESTART_EN
   task automatic test_sync_restart();
      int dv [4];
      logic [3:0] el, et;
      dv = '{2, 5, 7, 9};
      do_reset();
      for (int i = 0; i < 4; i++) begin
         wr_en  = 1'b1;
         wr_ch  = 2'(i);
         wr_div = 7'(dv[i]);
         cyc();
      end
      wr_en = 1'b0;
      cyc();
      ch_en = 4'b1111;
      for (int t = 0; t < 17; t++) cyc();
      sync_restart = 1'b1;
      cyc();
      sync_restart = 1'b0;
      n_chk++;
      if ({scaled_clk, tick} !== 8'h00)
         $display("FAIL sync_restart got=%b/%b want=0000/0000", scaled_clk, tick);
      else n_pass++;
      for (int j = 1; j <= 30; j++) begin
         cyc();
         for (int i = 0; i < 4; i++) begin
            el[i] = seg_lvl(j, dv[i], 1'b0);
            et[i] = seg_tick(j, dv[i]);
         end
         n_chk++;
         if ({scaled_clk, tick} !== {el, et})
            $display("FAIL sync_align j=%0d got=%b/%b want=%b/%b", j, scaled_clk, tick, el, et);
         else n_pass++;
      end
   endtask
`endif

   initial begin
`ifdef CLKDIV_SYNC_RESTART_EN
      sync_restart = 1'b0;
`endif
      test_reset();
      test_default();
      test_retarget();
      test_tc_write();
      test_park();
      test_freeze_and_reset();
      test_random();
`ifdef CLKDIV_SYNC_RESTART_EN
      test_sync_restart();
`endif
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
